// File: rtl/pit_table_if.sv
// Request/response bus for the Pending Interest Table.
//   req_*  : one Interest/Data lookup request (valid/ready handshake)
//   resp_* : lookup result (valid/ready handshake), held until accepted
// slave modport is used by pit_table; master modport by the requester.
interface pit_table_if #(
  parameter int PREFIX_W = 64,
  parameter int LEN_W    = 6,
  parameter int FACES    = 4,
  parameter int ADDR_W   = 32
);
  localparam int FACE_W = $clog2(FACES);

  logic                req_valid;
  logic                req_ready;
  logic                req_op;
  logic [PREFIX_W-1:0] req_prefix;
  logic [LEN_W-1:0]    req_len;
  logic [FACE_W-1:0]   req_face;

  logic                resp_valid;
  logic                resp_ready;
  logic [1:0]          resp_status;
  logic [FACES-1:0]    resp_faces;
  logic [ADDR_W-1:0]   resp_addr;

  modport slave (
    input  req_valid, req_op, req_prefix, req_len, req_face, resp_ready,
    output req_ready, resp_valid, resp_status, resp_faces, resp_addr
  );

  modport master (
    output req_valid, req_op, req_prefix, req_len, req_face, resp_ready,
    input  req_ready, resp_valid, resp_status, resp_faces, resp_addr
  );
endinterface

// File: rtl/pit_table.sv
// Pending Interest Table: open-addressed hash table with linear probing.
// Interests insert or aggregate a face into an entry; Data consumes it.
// Ports:
//   clk         : clock, all state on rising edge
//   rst         : asynchronous active-low reset
//   bus         : pit_table_if.slave request/response handshake
//   entry_count : number of valid entries
//   full        : entry_count == DEPTH
// The interface parameters must match PREFIX_W/LEN_W/FACES/ADDR_W here.
module pit_table #(
  parameter int PREFIX_W   = 64,
  parameter int LEN_W      = 6,
  parameter int DEPTH      = 1024,
  parameter int FACES      = 4,
  parameter int ADDR_W     = 32,
  parameter int BLOCK_SIZE = 1024,
  parameter int MAX_PROBE  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  pit_table_if.slave               bus,
  output logic [$clog2(DEPTH):0]   entry_count,
  output logic                     full
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int FACE_W = $clog2(FACES);
  localparam int KEY_W  = LEN_W + PREFIX_W;
  localparam int NSL    = (KEY_W + IDX_W - 1) / IDX_W;
  localparam int ENT_W  = LEN_W + PREFIX_W + FACES + ADDR_W;
  // Entry layout: {len, prefix, faces, addr}
  localparam int FC_LO  = ADDR_W;
  localparam int PF_LO  = ADDR_W + FACES;
  localparam int LN_LO  = ADDR_W + FACES + PREFIX_W;

  localparam logic [IDX_W-1:0] LAST_PROBE = IDX_W'(MAX_PROBE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W:0]   CNT_ONE    = (IDX_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BLOCK_SIZE);

  localparam logic [1:0] ST_NEW = 2'b00;
  localparam logic [1:0] ST_AGG = 2'b01;
  localparam logic [1:0] ST_DAT = 2'b10;
  localparam logic [1:0] ST_REJ = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_RESP} state_t;

  // ---------------------------------------------------------------------
  // Hash: XOR-fold of the zero-extended key in IDX_W-bit slices
  // ---------------------------------------------------------------------
  logic [NSL*IDX_W-1:0]      key_ext;
  logic [NSL:0][IDX_W-1:0]   hx;

  always_comb begin
    key_ext = '0;
    key_ext[KEY_W-1:0] = {bus.req_len, bus.req_prefix};
  end

  assign hx[0] = '0;
  generate
    for (genvar gi = 0; gi < NSL; gi++) begin : g_fold
      assign hx[gi+1] = hx[gi] ^ key_ext[gi*IDX_W +: IDX_W];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t               state_q, state_d;
  logic                 run_q;
  logic                 op_q, op_d;
  logic [FACE_W-1:0]    face_q, face_d;
  logic [LEN_W-1:0]     key_len_q, key_len_d;
  logic [PREFIX_W-1:0]  key_prefix_q, key_prefix_d;
  logic [IDX_W-1:0]     hash_q, hash_d;
  logic [IDX_W-1:0]     count_q, count_d;
  logic                 rd_vld_q, rd_vld_d;
  logic                 free_found_q, free_found_d;
  logic [IDX_W-1:0]     free_slot_q, free_slot_d;
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [IDX_W:0]       entry_count_q, entry_count_d;
  logic [ADDR_W-1:0]    next_addr_q, next_addr_d;
  logic [1:0]           resp_status_q, resp_status_d;
  logic [FACES-1:0]     resp_faces_q, resp_faces_d;
  logic [ADDR_W-1:0]    resp_addr_q, resp_addr_d;
  logic                 slot_valid_q;

  // Entry payload storage with registered read
  logic [ENT_W-1:0]     mem [DEPTH];
  logic [ENT_W-1:0]     rd_data_q;
  logic                 mem_we;
  logic [IDX_W-1:0]     mem_waddr;
  logic [ENT_W-1:0]     mem_wdata;
  logic [IDX_W-1:0]     rd_addr;

  logic [IDX_W-1:0]     cmp_slot;
  logic [LEN_W-1:0]     rd_len;
  logic [PREFIX_W-1:0]  rd_prefix;
  logic [FACES-1:0]     rd_faces;
  logic [ADDR_W-1:0]    rd_baddr;
  logic                 hit;
  logic                 have_free;
  logic [IDX_W-1:0]     free_idx;
  logic [FACES-1:0]     face_onehot;
  logic [FACES-1:0]     agg_faces;

  // Slot whose data sits in rd_data_q this cycle. The first PROBE cycle
  // only fetches slot hash; afterwards the read runs one slot ahead.
  assign cmp_slot    = hash_q + count_q;
  assign rd_addr     = rd_vld_q ? (cmp_slot + IDX_ONE) : cmp_slot;

  assign rd_len      = rd_data_q[LN_LO +: LEN_W];
  assign rd_prefix   = rd_data_q[PF_LO +: PREFIX_W];
  assign rd_faces    = rd_data_q[FC_LO +: FACES];
  assign rd_baddr    = rd_data_q[0 +: ADDR_W];

  assign hit         = slot_valid_q && (rd_len == key_len_q) && (rd_prefix == key_prefix_q);
  // Current slot counts as a free candidate on the final probe
  assign have_free   = free_found_q || !slot_valid_q;
  assign free_idx    = free_found_q ? free_slot_q : cmp_slot;
  assign face_onehot = {{(FACES-1){1'b0}}, 1'b1} << face_q;
  assign agg_faces   = rd_faces | face_onehot;

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    face_d         = face_q;
    key_len_d      = key_len_q;
    key_prefix_d   = key_prefix_q;
    hash_d         = hash_q;
    count_d        = count_q;
    rd_vld_d       = rd_vld_q;
    free_found_d   = free_found_q;
    free_slot_d    = free_slot_q;
    valid_d        = valid_q;
    entry_count_d  = entry_count_q;
    next_addr_d    = next_addr_q;
    resp_status_d  = resp_status_q;
    resp_faces_d   = resp_faces_q;
    resp_addr_d    = resp_addr_q;
    mem_we         = 1'b0;
    mem_waddr      = cmp_slot;
    mem_wdata      = rd_data_q;

    case (state_q)
      S_IDLE: begin
        if (run_q && bus.req_valid) begin
          op_d         = bus.req_op;
          face_d       = bus.req_face;
          key_len_d    = bus.req_len;
          key_prefix_d = bus.req_prefix;
          hash_d       = hx[NSL];
          count_d      = '0;
          rd_vld_d     = 1'b0;
          free_found_d = 1'b0;
          state_d      = S_PROBE;
        end
      end

      S_PROBE: begin
        if (!rd_vld_q) begin
          rd_vld_d = 1'b1;
        end else if (hit) begin
          state_d = S_RESP;
          if (!op_q) begin
            mem_we        = 1'b1;
            mem_wdata     = {rd_len, rd_prefix, agg_faces, rd_baddr};
            resp_status_d = ST_AGG;
            resp_faces_d  = agg_faces;
          end else begin
            valid_d[cmp_slot] = 1'b0;
            entry_count_d     = entry_count_q - CNT_ONE;
            resp_status_d     = ST_DAT;
            resp_faces_d      = rd_faces;
          end
          resp_addr_d = rd_baddr;
        end else if (count_q == LAST_PROBE) begin
          state_d = S_RESP;
          if (!op_q && have_free) begin
            mem_we            = 1'b1;
            mem_waddr         = free_idx;
            mem_wdata         = {key_len_q, key_prefix_q, face_onehot, next_addr_q};
            valid_d[free_idx] = 1'b1;
            entry_count_d     = entry_count_q + CNT_ONE;
            next_addr_d       = next_addr_q + ADDR_STEP;
            resp_status_d     = ST_NEW;
            resp_faces_d      = face_onehot;
            resp_addr_d       = next_addr_q;
          end else begin
            resp_status_d = ST_REJ;
            resp_faces_d  = '0;
            resp_addr_d   = '0;
          end
        end else begin
          count_d = count_q + IDX_ONE;
          if (!slot_valid_q && !free_found_q) begin
            free_found_d = 1'b1;
            free_slot_d  = cmp_slot;
          end
        end
      end

      S_RESP: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      run_q         <= 1'b0;
      op_q          <= 1'b0;
      face_q        <= '0;
      key_len_q     <= '0;
      key_prefix_q  <= '0;
      hash_q        <= '0;
      count_q       <= '0;
      rd_vld_q      <= 1'b0;
      free_found_q  <= 1'b0;
      free_slot_q   <= '0;
      valid_q       <= '0;
      entry_count_q <= '0;
      next_addr_q   <= '0;
      resp_status_q <= '0;
      resp_faces_q  <= '0;
      resp_addr_q   <= '0;
      slot_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= 1'b1;
      op_q          <= op_d;
      face_q        <= face_d;
      key_len_q     <= key_len_d;
      key_prefix_q  <= key_prefix_d;
      hash_q        <= hash_d;
      count_q       <= count_d;
      rd_vld_q      <= rd_vld_d;
      free_found_q  <= free_found_d;
      free_slot_q   <= free_slot_d;
      valid_q       <= valid_d;
      entry_count_q <= entry_count_d;
      next_addr_q   <= next_addr_d;
      resp_status_q <= resp_status_d;
      resp_faces_q  <= resp_faces_d;
      resp_addr_q   <= resp_addr_d;
      slot_valid_q  <= valid_q[rd_addr];
    end
  end

  // Payload is never reset; the valid bits alone decide occupancy
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rd_data_q <= mem[rd_addr];
  end

  assign bus.req_ready   = run_q && (state_q == S_IDLE);
  assign bus.resp_valid  = (state_q == S_RESP);
  assign bus.resp_status = resp_status_q;
  assign bus.resp_faces  = resp_faces_q;
  assign bus.resp_addr   = resp_addr_q;
  assign entry_count     = entry_count_q;
  assign full            = (entry_count_q == (IDX_W+1)'(DEPTH));
endmodule

// File: tb/tb_pit_table.sv
module tb_pit_table;
  localparam int PREFIX_W = 64;
  localparam int LEN_W    = 6;
  localparam int DEPTH    = 16;
  localparam int FACES    = 4;
  localparam int ADDR_W   = 32;

  localparam logic [1:0] NEW = 2'b00;
  localparam logic [1:0] AGG = 2'b01;
  localparam logic [1:0] DAT = 2'b10;
  localparam logic [1:0] REJ = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] entry_count;
  logic       full;
  int         checks = 0;
  int         errors = 0;

  pit_table_if #(.PREFIX_W(PREFIX_W), .LEN_W(LEN_W), .FACES(FACES), .ADDR_W(ADDR_W)) bus ();

  pit_table #(
    .PREFIX_W(PREFIX_W), .LEN_W(LEN_W), .DEPTH(DEPTH), .FACES(FACES),
    .ADDR_W(ADDR_W), .BLOCK_SIZE(1024), .MAX_PROBE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .entry_count(entry_count),
    .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request; hold = cycles to keep resp_ready low after resp_valid
  task automatic do_req(input string tag, input logic op, input logic [63:0] prefix,
                        input logic [1:0] face, input logic [1:0] exp_st,
                        input logic [3:0] exp_fc, input logic [31:0] exp_ad,
                        input int exp_lat, input int hold);
    int lat;
    bit seen;
    @(negedge clk);
    check({tag, "/req_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_prefix = prefix;
    bus.req_len    = 6'd8;
    bus.req_face   = face;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      seen = bus.resp_valid;
    end
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/status"}, 64'(bus.resp_status), 64'(exp_st));
    check({tag, "/faces"}, 64'(bus.resp_faces), 64'(exp_fc));
    check({tag, "/addr"}, 64'(bus.resp_addr), 64'(exp_ad));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "/hold"},
            {26'd0, bus.resp_valid, bus.req_ready, bus.resp_status, bus.resp_faces, bus.resp_addr},
            {26'd0, 1'b1, 1'b0, exp_st, exp_fc, exp_ad});
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    check({tag, "/consumed"}, {62'd0, bus.resp_valid, bus.req_ready}, {62'd0, 1'b0, 1'b1});
    $display("req %s op=%0d prefix=%0h face=%0d -> status=%0d faces=%b addr=%0d lat=%0d count=%0d",
             tag, op, prefix, face, bus.resp_status, bus.resp_faces, bus.resp_addr, lat, entry_count);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = 1'b0;
    bus.req_prefix = '0;
    bus.req_len    = '0;
    bus.req_face   = '0;
    bus.resp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset/outputs",
          {25'd0, bus.req_ready, bus.resp_valid, bus.resp_status, bus.resp_faces, bus.resp_addr},
          64'd0);
    check("reset/count", {58'd0, full, entry_count}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 check("reset/ready_after", 64'(bus.req_ready), 64'd1);

    // 1. first insert
    do_req("A_new", 1'b0, 64'h1, 2'd2, NEW, 4'b0100, 32'd0, 5, 0);
    check("A_new/count", 64'(entry_count), 64'd1);

    // 2. aggregation, repeated face still AGG
    do_req("A_agg0", 1'b0, 64'h1, 2'd0, AGG, 4'b0101, 32'd0, 2, 0);
    do_req("A_agg0b", 1'b0, 64'h1, 2'd0, AGG, 4'b0101, 32'd0, 2, 0);

    // 3. collision insert into slot 10, then consume
    do_req("B_new", 1'b0, 64'h10, 2'd1, NEW, 4'b0010, 32'd1024, 5, 0);
    check("B_new/count", 64'(entry_count), 64'd2);
    do_req("B_data", 1'b1, 64'h10, 2'd0, DAT, 4'b0010, 32'd1024, 3, 0);
    check("B_data/count", 64'(entry_count), 64'd1);

    // 4. fill slots 9..12, window exhausted -> REJECT
    do_req("B_new2", 1'b0, 64'h10, 2'd1, NEW, 4'b0010, 32'd2048, 5, 0);
    do_req("C_new", 1'b0, 64'h100, 2'd3, NEW, 4'b1000, 32'd3072, 5, 0);
    do_req("D_new", 1'b0, 64'h1000, 2'd0, NEW, 4'b0001, 32'd4096, 5, 0);
    do_req("E_rej", 1'b0, 64'h10000, 2'd0, REJ, 4'b0000, 32'd0, 5, 0);
    check("E_rej/count_full", {58'd0, full, entry_count}, {58'd0, 1'b0, 5'd4});
    do_req("X2_data_rej", 1'b1, 64'h2, 2'd0, REJ, 4'b0000, 32'd0, 5, 0);
    check("X2/count", 64'(entry_count), 64'd4);

    // 5. wrap-around: hash 15 -> slots 15, 0, 1, 2
    do_req("W7_new", 1'b0, 64'h7, 2'd0, NEW, 4'b0001, 32'd5120, 5, 0);
    do_req("W70_new", 1'b0, 64'h70, 2'd1, NEW, 4'b0010, 32'd6144, 5, 0);
    do_req("W700_new", 1'b0, 64'h700, 2'd2, NEW, 4'b0100, 32'd7168, 5, 0);
    do_req("W7000_new", 1'b0, 64'h7000, 2'd3, NEW, 4'b1000, 32'd8192, 5, 0);
    check("wrap/count", 64'(entry_count), 64'd8);
    do_req("W700_data", 1'b1, 64'h700, 2'd0, DAT, 4'b0100, 32'd7168, 4, 0);
    do_req("W7000_agg", 1'b0, 64'h7000, 2'd0, AGG, 4'b1001, 32'd8192, 5, 0);
    check("wrap/count2", 64'(entry_count), 64'd7);

    // 6. back-pressure, then reset mid-probe
    do_req("A_hold", 1'b0, 64'h1, 2'd1, AGG, 4'b0111, 32'd0, 2, 10);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_op     = 1'b0;
    bus.req_prefix = 64'h3;
    bus.req_len    = 6'd8;
    bus.req_face   = 2'd0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort/outputs",
          {25'd0, bus.req_ready, bus.resp_valid, bus.resp_status, bus.resp_faces, bus.resp_addr},
          64'd0);
    check("abort/count", {58'd0, full, entry_count}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_req("A_after_rst", 1'b0, 64'h1, 2'd2, NEW, 4'b0100, 32'd0, 5, 0);
    check("A_after_rst/count", 64'(entry_count), 64'd1);
    do_req("W7_gone", 1'b1, 64'h7, 2'd0, REJ, 4'b0000, 32'd0, 5, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
